vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 155 +++++++++++++++
 tb/tb_vend_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending sequencer: accumulates coin credit, grants one slot round-robin,
// supervises the dispenser with a timeout and returns the remaining credit as change.
module vend_sequencer #(
  parameter int DISP_TIMEOUT = 16,
  parameter int MAX_CREDIT   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic [3:0] sel_req,
  input  logic       cancel,
  input  logic [3:0] stock_empty,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_price,
  input  logic       disp_done,
  output logic       disp_go,
  output logic [1:0] disp_sel,
  output logic       change_valid,
  output logic [7:0] change_amt,
  output logic [7:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       soldout,
  output logic       fault
);
  localparam int NUM_SLOTS = 4;
  localparam int TW        = $clog2(DISP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

  state_t                    state, state_n;
  logic [NUM_SLOTS-1:0][7:0] price, price_n;
  logic [7:0]                price_lat, price_lat_n;
  logic [7:0]                credit_n, change_amt_n;
  logic [1:0]                rr, rr_n, disp_sel_n;
  logic [TW-1:0]             timer, timer_n;
  logic                      disp_go_n, change_valid_n, coin_reject_n, soldout_n, fault_n;
  logic [NUM_SLOTS-1:0]      elig;
  logic                      grant;
  logic [1:0]                gnt_idx;
  logic [8:0]                coin_sum;

  // Eligibility looks at the credit register, so a same-cycle coin never funds a grant.
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign elig[i] = sel_req[i] & ~stock_empty[i] & (price[i] <= credit);
  end

  assign coin_sum = {1'b0, credit} + {1'b0, coin_value};

  always_comb begin
    grant   = 1'b0;
    gnt_idx = rr;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (!grant && elig[rr + 2'(k)]) begin
        grant   = 1'b1;
        gnt_idx = rr + 2'(k);
      end
    end
  end

  always_comb begin
    state_n        = state;
    price_n        = price;
    price_lat_n    = price_lat;
    credit_n       = credit;
    rr_n           = rr;
    disp_sel_n     = disp_sel;
    timer_n        = timer;
    disp_go_n      = 1'b0;
    change_valid_n = 1'b0;
    change_amt_n   = '0;
    coin_reject_n  = 1'b0;
    soldout_n      = 1'b0;
    fault_n        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_we) price_n[cfg_addr] = cfg_price;
        soldout_n = |(sel_req & stock_empty);
        if (coin_valid) begin
          if (coin_sum <= 9'(MAX_CREDIT)) credit_n = coin_sum[7:0];
          else coin_reject_n = 1'b1;
        end
        if (grant) begin
          state_n     = DISPENSE;
          disp_go_n   = 1'b1;
          disp_sel_n  = gnt_idx;
          price_lat_n = price[gnt_idx];
          rr_n        = gnt_idx + 2'd1;
          timer_n     = '0;
        end else if (cancel && credit != 8'd0) begin
          state_n = CHANGE;
        end
      end
      DISPENSE: begin
        coin_reject_n = coin_valid;
        if (disp_done) begin
          credit_n = credit - price_lat;
          state_n  = CHANGE;
        end else if (timer == TW'(DISP_TIMEOUT - 1)) begin
          fault_n = 1'b1;
          state_n = CHANGE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      CHANGE: begin
        coin_reject_n = coin_valid;
        if (credit != 8'd0) begin
          change_valid_n = 1'b1;
          change_amt_n   = credit;
        end
        credit_n = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      price        <= {8'd100, 8'd75, 8'd50, 8'd25};
      price_lat    <= '0;
      credit       <= '0;
      rr           <= '0;
      timer        <= '0;
      disp_sel     <= '0;
      disp_go      <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      soldout      <= 1'b0;
      fault        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      price        <= price_n;
      price_lat    <= price_lat_n;
      credit       <= credit_n;
      rr           <= rr_n;
      timer        <= timer_n;
      disp_sel     <= disp_sel_n;
      disp_go      <= disp_go_n;
      change_valid <= change_valid_n;
      change_amt   <= change_amt_n;
      coin_reject  <= coin_reject_n;
      soldout      <= soldout_n;
      fault        <= fault_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios plus random traffic against a
// transaction-level model of credit, grants, dispense outcome and change.
module tb_vend_sequencer;
  localparam int DISP_TIMEOUT = 16;
  localparam int MAX_CREDIT   = 250;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = '0;
  logic [3:0] sel_req = '0;
  logic       cancel = 1'b0;
  logic [3:0] stock_empty = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_price = '0;
  logic       disp_done = 1'b0;
  logic       disp_go, change_valid, busy, coin_reject, soldout, fault;
  logic [1:0] disp_sel;
  logic [7:0] change_amt, credit;

  vend_sequencer #(.DISP_TIMEOUT(DISP_TIMEOUT), .MAX_CREDIT(MAX_CREDIT)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_req(sel_req), .cancel(cancel), .stock_empty(stock_empty), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_price(cfg_price), .disp_done(disp_done),
    .disp_go(disp_go), .disp_sel(disp_sel), .change_valid(change_valid),
    .change_amt(change_amt), .credit(credit), .busy(busy), .coin_reject(coin_reject),
    .soldout(soldout), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a machine is either free, waiting on a vend (age = done-less cycles), or owes a refund.
  int m_credit = 0, m_rr = 0, m_vend_age = -1, m_lat = 0;
  bit m_refund = 1'b0;
  int m_price[4] = '{25, 50, 75, 100};
  bit e_go = 0, e_cv = 0, e_rej = 0, e_sold = 0, e_fault = 0, e_busy = 0;
  int e_sel = 0, e_amt = 0;

  task automatic model_step();
    int g, s, nc;
    e_go = 0; e_cv = 0; e_amt = 0; e_rej = 0; e_sold = 0; e_fault = 0;
    if (m_vend_age < 0 && !m_refund) begin
      g = -1;
      for (int k = 0; k < 4; k++) begin
        s = (m_rr + k) % 4;
        if (g < 0 && sel_req[s] && !stock_empty[s] && m_price[s] <= m_credit) g = s;
      end
      e_sold = |(sel_req & stock_empty);
      nc = m_credit;
      if (coin_valid) begin
        if (m_credit + int'(coin_value) <= MAX_CREDIT) nc = m_credit + int'(coin_value);
        else e_rej = 1;
      end
      if (g >= 0) begin
        m_vend_age = 0; m_lat = m_price[g]; e_go = 1; e_sel = g; m_rr = (g + 1) % 4;
      end else if (cancel && m_credit > 0) begin
        m_refund = 1;
      end
      if (cfg_we) m_price[cfg_addr] = int'(cfg_price);
      m_credit = nc;
    end else if (m_vend_age >= 0) begin
      e_rej = coin_valid;
      if (disp_done) begin
        m_credit = m_credit - m_lat; m_vend_age = -1; m_refund = 1;
      end else if (m_vend_age == DISP_TIMEOUT - 1) begin
        e_fault = 1; m_vend_age = -1; m_refund = 1;
      end else begin
        m_vend_age++;
      end
    end else begin
      e_rej = coin_valid;
      if (m_credit > 0) begin e_cv = 1; e_amt = m_credit; end
      m_credit = 0; m_refund = 0;
    end
    e_busy = (m_vend_age >= 0) || m_refund;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_credit = 0; m_rr = 0; m_vend_age = -1; m_lat = 0; m_refund = 0;
      m_price = '{25, 50, 75, 100};
      e_go = 0; e_cv = 0; e_rej = 0; e_sold = 0; e_fault = 0; e_busy = 0; e_sel = 0; e_amt = 0;
    end else begin
      model_step();
    end
  end

  int cyc = 0, go_cyc = 0, fault_cyc = 0, last_amt = -1;
  int grants[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    chk("disp_go", disp_go, e_go);
    chk("disp_sel", disp_sel, e_sel);
    chk("change_valid", change_valid, e_cv);
    if (e_cv) chk("change_amt", change_amt, e_amt);
    chk("credit", credit, m_credit);
    chk("busy", busy, e_busy);
    chk("coin_reject", coin_reject, e_rej);
    chk("soldout", soldout, e_sold);
    chk("fault", fault, e_fault);
    if (disp_go) begin grants.push_back(int'(disp_sel)); go_cyc = cyc; end
    if (change_valid) last_amt = int'(change_amt);
    if (fault) fault_cyc = cyc;
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic put_coin(input int v);
    coin_valid = 1'b1; coin_value = 8'(v); tick(); coin_valid = 1'b0;
  endtask

  task automatic wait_go(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (disp_go) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    chk(name, ok, 1);
  endtask

  task automatic pulse_done_after(input int n);
    repeat (n) tick();
    disp_done = 1'b1; tick(); disp_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_go", disp_go, 0);
    reset = 1'b0;

    // three quarters, buy slot 1, expect a quarter back
    put_coin(25); put_coin(25); put_coin(25);
    sel_req = 4'b0010; tick(); sel_req = '0;
    wait_go("t1_go_seen");
    chk("t1_sel", disp_sel, 1);
    pulse_done_after(3);
    last_amt = -1;
    wait_idle("t1_idle"); tick();
    chk("t1_change", last_amt, 25);
    chk("t1_credit", credit, 0);

    // credit ceiling
    put_coin(100); put_coin(100); put_coin(25); put_coin(10); put_coin(5);
    @(negedge clk); chk("t2_credit240", credit, 240);
    put_coin(25);
    @(negedge clk); chk("t2_reject", coin_reject, 1); chk("t2_hold240", credit, 240);
    put_coin(10);
    @(negedge clk); chk("t2_credit250", credit, 250);
    cancel = 1'b1; tick(); cancel = 1'b0;
    last_amt = -1;
    wait_idle("t2_idle"); tick();
    chk("t2_change", last_amt, 250);

    // round robin over three refilled vends
    reset = 1'b1; tick(); reset = 1'b0;
    grants.delete();
    sel_req = 4'b1111;
    for (int v = 0; v < 3; v++) begin
      put_coin(100);
      wait_go("t3_go_seen");
      pulse_done_after(1);
      wait_idle("t3_idle");
    end
    sel_req = '0;
    for (int i = 0; i < 3; i++) chk("t3_grant_order", (i < grants.size()) ? grants[i] : -1, i);

    // sold-out slot, then cancel
    put_coin(50);
    grants.delete();
    sel_req = 4'b0001; stock_empty = 4'b0001; tick(); sel_req = '0; stock_empty = '0;
    @(negedge clk); chk("t4_soldout", soldout, 1); chk("t4_no_go", disp_go, 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    last_amt = -1;
    wait_idle("t4_idle"); tick();
    chk("t4_change", last_amt, 50);
    chk("t4_no_grant", grants.size(), 0);

    // dispenser never answers on slot 3
    put_coin(100);
    sel_req = 4'b1000; tick(); sel_req = '0;
    wait_go("t5_go_seen");
    chk("t5_sel", disp_sel, 3);
    last_amt = -1;
    wait_idle("t5_idle"); tick();
    chk("t5_fault_delay", fault_cyc - go_cyc, DISP_TIMEOUT);
    chk("t5_change", last_amt, 100);

    // price write while dispensing must not land
    put_coin(100);
    sel_req = 4'b0001; tick(); sel_req = '0;
    wait_go("t6_go_seen");
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_price = 8'd5; tick(); cfg_we = 1'b0;
    pulse_done_after(2);
    wait_idle("t6_idle");
    grants.delete();
    put_coin(10);
    sel_req = 4'b0001; repeat (3) tick(); sel_req = '0;
    chk("t6_price_kept", grants.size(), 0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    wait_idle("t6_idle2");

    // reset in the middle of a vend
    put_coin(100);
    sel_req = 4'b0001; tick(); sel_req = '0;
    wait_go("t7_go_seen");
    #2 reset = 1'b1;
    #1;
    chk("t7_go_drop", disp_go, 0);
    chk("t7_credit", credit, 0);
    chk("t7_busy", busy, 0);
    chk("t7_no_change", change_valid, 0);
    tick(); reset = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      coin_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: coin_value = 8'd5;
        1: coin_value = 8'd10;
        2: coin_value = 8'd25;
        3: coin_value = 8'd50;
        4: coin_value = 8'd100;
        default: coin_value = 8'($urandom_range(0, 255));
      endcase
      sel_req     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      stock_empty = 4'($urandom) & 4'($urandom);
      cancel      = ($urandom_range(0, 15) == 0);
      cfg_we      = ($urandom_range(0, 19) == 0);
      cfg_addr    = 2'($urandom);
      cfg_price   = 8'($urandom_range(0, 120));
      disp_done   = ($urandom_range(0, 6) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      tick();
    end
    coin_valid = 0; sel_req = '0; stock_empty = '0; cancel = 0; cfg_we = 0; disp_done = 0; reset = 0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
